pc_unit: RTL
============

Name: pc_unit

Overview:
- Fetch-side program-counter unit for the 5-stage MIPS pipeline; successor to the combinational next-PC logic.
- Holds the IF-stage PC register and resolves the next PC from ID-stage branch/jump decisions, interrupts and ERET.
- Widths, vectors and the branch-code table are parametrised.
- Latches interrupt/ERET requests that arrive while the pipeline is frozen and counts taken redirects.

Parameters:
ADDR_W, 32, PC/address width (>=28)
RESET_PC, 32'h0000_3000, PC value after reset
EXC_VEC, 32'h0000_4180, exception/interrupt entry vector
CNT_W, 16, width of the taken-redirect counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  ID hazard stall: PC holds, ID branch/jump ignored this cycle
freeze  in  1  bus-wait freeze: PC holds and interrupt/ERET are deferred
pc4_id  in  ADDR_W  PC+4 of the instruction in ID
imm16  in  16  ID branch offset
jidx26  in  26  ID jump index
branch  in  3  001 beq, 010 bne, 100 blez, 101 bgtz, 110 bltz, 111 bgez, others none
jump  in  3  1x0 = j/jal, 11x = jr/jalr, 0xx = none
rs_val  in  ADDR_W  forwarded rs operand
rt_val  in  ADDR_W  forwarded rt operand
interrupt  in  1  one-cycle request to enter EXC_VEC
eret  in  1  one-cycle ERET request
epc  in  ADDR_W  return address for ERET
pc_if  out  ADDR_W  current fetch PC (registered)
pc4_if  out  ADDR_W  pc_if+4 (combinational from pc_if)
redirect  out  1  registered; 1 for one cycle after any non-sequential PC update
redir_cnt  out  CNT_W  count of taken redirects, saturating
int_pend  out  1  deferred interrupt pending
eret_pend  out  1  deferred ERET pending

Behaviour:
- Reset (synchronous): pc_if=RESET_PC, redirect=0, redir_cnt=0, int_pend=0, eret_pend=0. Reset overrides every other input in the same cycle.
- Effective requests: irq = interrupt|int_pend; ret = eret|eret_pend.
- When freeze=1:
  - pc_if, redirect and redir_cnt hold.
  - int_pend |= interrupt; eret_pend |= eret.
  - Branch/jump inputs are ignored.
- When freeze=0, the next PC takes the first match in this priority order:
  1. irq -> EXC_VEC. Clear both pend flags, including any pending ERET (the handler re-issues it).
  2. ret -> epc. Clear eret_pend.
  3. stall=1 -> hold pc_if. No redirect.
  4. Branch taken -> pc4_id + sext(imm16)<<2.
  5. j/jal -> {pc4_id[31:28], jidx26, 2'b00}.
  6. jr/jalr -> rs_val.
  7. Otherwise -> pc_if+4.
- Branch conditions:
  - beq: rs==rt. bne: rs!=rt.
  - blez / bgtz / bltz / bgez compare signed rs against 0.
- Arithmetic:
  - Modulo 2^ADDR_W; wrap-around at the top of the address space is silent.
  - For ADDR_W>32, jump targets take the upper bits from pc4_id[ADDR_W-1:28].
- redirect is set to 1 for one cycle when cases 1, 2, 4, 5 or 6 fire; otherwise 0.
- redir_cnt increments by 1 on each redirect and saturates at all-ones.
- An interrupt that arrives on the same cycle freeze falls is taken immediately (irq includes the raw input).
- Latency: one clock from a decision to the new pc_if.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Add output adel (1, registered).
  - If case 6 (jr/jalr) or case 2 (ret) selects a target with bits [1:0]!=0, pc_if takes EXC_VEC instead and adel=1 for one cycle.
  - redir_cnt still increments.
  - adel resets to 0.
- When undefined: no adel port, and misaligned targets load unchanged.

Test Plan:
- Reset sequence: reset=1 for 2 cycles -> pc_if=0x3000, redir_cnt=0. Then 3 idle cycles -> 0x3004, 0x3008, 0x300C.
- beq taken: pc4_id=0x3008, imm16=0xFFFE, rs=rt=5 -> next pc_if=0x3000, redirect=1, redir_cnt=1. Same stimulus with rt=6 -> sequential +4.
- bgez vs bltz with rs=0x80000000: bgez not taken; bltz taken to pc4_id+(imm16<<2). blez with rs=0 -> taken.
- Interrupt during freeze: freeze=1, interrupt pulse -> int_pend=1 and pc_if holds. Freeze drops -> pc_if=0x4180, int_pend=0.
- Priority: interrupt, eret and jr asserted in the same cycle with freeze=0 -> pc_if=0x4180. eret with stall=1 -> pc_if=epc.
- Counter saturation with CNT_W=2: 5 consecutive jumps -> redir_cnt=3. With PC_ALIGN_CHECK_EN, jr to 0x3002 -> pc_if=0x4180, adel=1.

Source files
------------

// File: rtl/pc_unit_if.sv
// pc_unit_if: ID-side decision inputs and IF-side PC outputs of pc_unit.
// Optional macro PC_ALIGN_CHECK_EN adds the adel (address-error) output.
interface pc_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              freeze;
  logic [ADDR_W-1:0] pc4_id;
  logic [15:0]       imm16;
  logic [25:0]       jidx26;
  logic [2:0]        branch;
  logic [2:0]        jump;
  logic [ADDR_W-1:0] rs_val;
  logic [ADDR_W-1:0] rt_val;
  logic              interrupt;
  logic              eret;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pc_if;
  logic [ADDR_W-1:0] pc4_if;
  logic              redirect;
  logic [CNT_W-1:0]  redir_cnt;
  logic              int_pend;
  logic              eret_pend;
`ifdef PC_ALIGN_CHECK_EN
  logic              adel;
`endif

  // Pipeline side: drives the decisions, observes the fetch PC.
  modport master (
    output stall, freeze, pc4_id, imm16, jidx26, branch, jump,
           rs_val, rt_val, interrupt, eret, epc,
    input  pc_if, pc4_if, redirect, redir_cnt, int_pend, eret_pend
`ifdef PC_ALIGN_CHECK_EN
    , input adel
`endif
  );

  // PC unit side.
  modport slave (
    input  stall, freeze, pc4_id, imm16, jidx26, branch, jump,
           rs_val, rt_val, interrupt, eret, epc,
    output pc_if, pc4_if, redirect, redir_cnt, int_pend, eret_pend
`ifdef PC_ALIGN_CHECK_EN
    , output adel
`endif
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with next-PC resolution for branches,
// jumps, interrupts and ERET; defers interrupt/ERET while frozen and counts
// taken redirects (saturating).
// Optional macro PC_ALIGN_CHECK_EN: misaligned ERET/jr targets divert to
// EXC_VEC and raise adel for one cycle.
module pc_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(32'h0000_4180),
  parameter int                CNT_W    = 16
) (
  input logic        clk,
  input logic        reset,
  pc_unit_if.slave   bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic [CNT_W-1:0]  redir_cnt_q, redir_cnt_d;
  logic              int_pend_q, int_pend_d;
  logic              eret_pend_q, eret_pend_d;
`ifdef PC_ALIGN_CHECK_EN
  logic              adel_q, adel_d;
`endif

  logic              br_taken;
  logic              is_j;
  logic              is_jr;
  logic              irq;
  logic              ret;
  logic              take;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] seq_pc;

  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'({28{1'b1}});

  assign irq    = bus.interrupt | int_pend_q;
  assign ret    = bus.eret | eret_pend_q;
  assign seq_pc = pc_q + ADDR_W'(4);

  // Jump decode: 1x0 is j/jal and wins over 11x (jr/jalr) on code 110.
  assign is_j  = bus.jump[2] & ~bus.jump[0];
  assign is_jr = bus.jump[2] &  bus.jump[1];

  // Branch target: sign-extended word offset relative to PC+4 of the branch.
  assign br_target = bus.pc4_id +
                     {{(ADDR_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};

  // Jump target: region bits of pc4_id above bit 27, index below.
  assign j_target = (bus.pc4_id & ~LOW28_MASK) |
                    ADDR_W'({bus.jidx26, 2'b00});

  // Branch condition evaluation on the forwarded operands.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    br_taken = 1'b0;
    unique case (bus.branch)
      3'b001:  br_taken = (bus.rs_val == bus.rt_val);
      3'b010:  br_taken = (bus.rs_val != bus.rt_val);
      3'b100:  br_taken = bus.rs_val[ADDR_W-1] | (bus.rs_val == '0);
      3'b101:  br_taken = ~bus.rs_val[ADDR_W-1] & (bus.rs_val != '0);
      3'b110:  br_taken = bus.rs_val[ADDR_W-1];
      3'b111:  br_taken = ~bus.rs_val[ADDR_W-1];
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state selection: freeze defers, otherwise first match by priority.
  always_comb begin
    pc_d        = pc_q;
    redirect_d  = redirect_q;
    redir_cnt_d = redir_cnt_q;
    int_pend_d  = int_pend_q;
    eret_pend_d = eret_pend_q;
    take        = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    adel_d      = adel_q;
`endif
    if (bus.freeze) begin
      int_pend_d  = int_pend_q | bus.interrupt;
      eret_pend_d = eret_pend_q | bus.eret;
    end else begin
`ifdef PC_ALIGN_CHECK_EN
      adel_d = 1'b0;
`endif
      if (irq) begin
        // A pending ERET is dropped too; the handler re-issues it.
        pc_d        = EXC_VEC;
        take        = 1'b1;
        int_pend_d  = 1'b0;
        eret_pend_d = 1'b0;
      end else if (ret) begin
        pc_d        = bus.epc;
        take        = 1'b1;
        eret_pend_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        if (bus.epc[1:0] != 2'b00) begin
          pc_d   = EXC_VEC;
          adel_d = 1'b1;
        end
`endif
      end else if (bus.stall) begin
        pc_d = pc_q;
      end else if (br_taken) begin
        pc_d = br_target;
        take = 1'b1;
      end else if (is_j) begin
        pc_d = j_target;
        take = 1'b1;
      end else if (is_jr) begin
        pc_d = bus.rs_val;
        take = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        if (bus.rs_val[1:0] != 2'b00) begin
          pc_d   = EXC_VEC;
          adel_d = 1'b1;
        end
`endif
      end else begin
        pc_d = seq_pc;
      end
      redirect_d = take;
      if (take && (redir_cnt_q != '1)) begin
        redir_cnt_d = redir_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      pc_q        <= RESET_PC;
      redirect_q  <= 1'b0;
      redir_cnt_q <= '0;
      int_pend_q  <= 1'b0;
      eret_pend_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      adel_q      <= 1'b0;
`endif
    end else begin
      pc_q        <= pc_d;
      redirect_q  <= redirect_d;
      redir_cnt_q <= redir_cnt_d;
      int_pend_q  <= int_pend_d;
      eret_pend_q <= eret_pend_d;
`ifdef PC_ALIGN_CHECK_EN
      adel_q      <= adel_d;
`endif
    end
  end

  assign bus.pc_if     = pc_q;
  assign bus.pc4_if    = seq_pc;
  assign bus.redirect  = redirect_q;
  assign bus.redir_cnt = redir_cnt_q;
  assign bus.int_pend  = int_pend_q;
  assign bus.eret_pend = eret_pend_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.adel      = adel_q;
`endif

endmodule
